// File: rtl/ip_codma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ip_codma_bus_arbiter
// Round-robin arbiter that shares the CODMA system-bus master port between
// the read machine (0), the write machine (1) and descriptor fetch (2).
// It latches the winner and its transfer size, asks for the bus, hands
// ownership to the winner until the expected number of beats completes,
// then rotates priority.
//
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   stop_i             abort to idle, drop grants, keep priority pointer
//   req_i / size_i     per-requester level request and size code (3, 8, 9)
//   grant_o, owner_o   one-hot ownership (owned state only), latched winner
//   bus_req_o          system bus request (ask state only)
//   bus_size_o         latched size of the owner
//   bus_grant_i        system bus grant
//   bus_beat_i         one 64-bit beat completed
//   bus_error_i        system bus error
//   busy_o             arbiter not idle
//   error_o            pulse: bus error, illegal size or timeout
//   timeout_o          pulse: timeout (always alongside error_o)
// ---------------------------------------------------------------------------
module ip_codma_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 stop_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*4-1:0] size_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [2:0]           owner_o,
    output logic                 bus_req_o,
    output logic [3:0]           bus_size_o,
    input  logic                 bus_grant_i,
    input  logic                 bus_beat_i,
    input  logic                 bus_error_i,
    output logic                 busy_o,
    output logic                 error_o,
    output logic                 timeout_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ARB_IDLE, ARB_ASK, ARB_OWNED, ARB_RELEASE} arb_state_e;

    arb_state_e    r_state, w_state_next;
    logic [2:0]    r_owner, w_owner_next;
    logic [3:0]    r_size, w_size_next;
    logic [2:0]    r_beats_needed, w_beats_next;
    logic [2:0]    r_beat_cnt, w_beat_cnt_next;
    logic [TW-1:0] r_idle_cnt, w_idle_next;
    logic [2:0]    r_rr_ptr, w_rr_next;
    logic          r_error, w_error_next;
    logic          r_timeout, w_timeout_next;

    // Padded copies so that 3-bit indices select without width games.
    logic [7:0]    w_req_pad;
    logic [31:0]   w_size_all;
    logic          w_win_found;
    logic [2:0]    w_win_idx;
    logic [2:0]    w_k;
    logic [3:0]    w_win_size;
    logic [2:0]    w_win_beats;
    logic          w_win_illegal;

    assign w_req_pad  = 8'(req_i);
    assign w_size_all = 32'(size_i);

    // Round-robin pick: first set request scanning upward from r_rr_ptr.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_k         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_k = 3'((32'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_win_found && w_req_pad[w_k]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_k;
            end
        end
        w_win_size = w_size_all[{w_win_idx, 2'b00} +: 4];
    end

    // Size code to beat count; anything else is an illegal request.
    always_comb begin
        w_win_beats   = '0;
        w_win_illegal = 1'b0;
        case (w_win_size)
            4'd3:    w_win_beats = 3'd1;
            4'd8:    w_win_beats = 3'd3;
            4'd9:    w_win_beats = 3'd4;
            default: w_win_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_size_next     = r_size;
        w_beats_next    = r_beats_needed;
        w_beat_cnt_next = r_beat_cnt;
        w_idle_next     = r_idle_cnt;
        w_rr_next       = r_rr_ptr;
        w_error_next    = 1'b0;
        w_timeout_next  = 1'b0;
        if (stop_i) begin
            w_state_next    = ARB_IDLE;
            w_owner_next    = '0;
            w_size_next     = '0;
            w_beat_cnt_next = '0;
            w_idle_next     = '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_win_found) begin
                        w_owner_next = w_win_idx;
                        w_size_next  = w_win_size;
                        w_beats_next = w_win_beats;
                        if (w_win_illegal) begin
                            w_error_next = 1'b1;
                            w_state_next = ARB_RELEASE;
                        end else begin
                            w_state_next = ARB_ASK;
                        end
                    end
                end
                ARB_ASK: begin
                    if (bus_error_i) begin
                        w_error_next = 1'b1;
                        w_state_next = ARB_RELEASE;
                    end else if (!w_req_pad[r_owner]) begin
                        w_state_next = ARB_RELEASE;
                    end else if (bus_grant_i) begin
                        w_state_next = ARB_OWNED;
                    end
                end
                ARB_OWNED: begin
                    // A beat restarts the idle window, so it can never coincide
                    // with a timeout; req_i is deliberately ignored here.
                    if (bus_error_i) begin
                        w_error_next = 1'b1;
                        w_state_next = ARB_RELEASE;
                    end else if (!bus_beat_i && r_idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        w_error_next   = 1'b1;
                        w_timeout_next = 1'b1;
                        w_state_next   = ARB_RELEASE;
                    end else if (bus_beat_i) begin
                        w_beat_cnt_next = r_beat_cnt + 3'd1;
                        w_idle_next     = '0;
                        if (r_beat_cnt + 3'd1 == r_beats_needed) begin
                            w_state_next = ARB_RELEASE;
                        end
                    end else begin
                        w_idle_next = r_idle_cnt + TW'(1);
                    end
                end
                ARB_RELEASE: begin
                    w_rr_next       = 3'((32'(r_owner) + 1) % NUM_REQ);
                    w_beat_cnt_next = '0;
                    w_idle_next     = '0;
                    w_state_next    = ARB_IDLE;
                end
                default: w_state_next = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state        <= ARB_IDLE;
            r_owner        <= '0;
            r_size         <= '0;
            r_beats_needed <= '0;
            r_beat_cnt     <= '0;
            r_idle_cnt     <= '0;
            r_rr_ptr       <= '0;
            r_error        <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_owner        <= w_owner_next;
            r_size         <= w_size_next;
            r_beats_needed <= w_beats_next;
            r_beat_cnt     <= w_beat_cnt_next;
            r_idle_cnt     <= w_idle_next;
            r_rr_ptr       <= w_rr_next;
            r_error        <= w_error_next;
            r_timeout      <= w_timeout_next;
        end
    end

    // Outputs decode registered state only.
    assign grant_o    = (r_state == ARB_OWNED) ? NUM_REQ'(8'd1 << r_owner) : '0;
    assign owner_o    = r_owner;
    assign bus_req_o  = (r_state == ARB_ASK);
    assign bus_size_o = r_size;
    assign busy_o     = (r_state != ARB_IDLE);
    assign error_o    = r_error;
    assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ip_codma_bus_arbiter
// Directed self-checking bench for ip_codma_bus_arbiter (NUM_REQ=3,
// TIMEOUT_CYCLES=8). Inputs change 1 ns after each rising edge and outputs
// are checked at that point, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_ip_codma_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        stop_i;
    logic [2:0]  req_i;
    logic [11:0] size_i;
    logic [2:0]  grant_o;
    logic [2:0]  owner_o;
    logic        bus_req_o;
    logic [3:0]  bus_size_o;
    logic        bus_grant_i;
    logic        bus_beat_i;
    logic        bus_error_i;
    logic        busy_o;
    logic        error_o;
    logic        timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    ip_codma_bus_arbiter #(
        .NUM_REQ        (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .stop_i      (stop_i),
        .req_i       (req_i),
        .size_i      (size_i),
        .grant_o     (grant_o),
        .owner_o     (owner_o),
        .bus_req_o   (bus_req_o),
        .bus_size_o  (bus_size_o),
        .bus_grant_i (bus_grant_i),
        .bus_beat_i  (bus_beat_i),
        .bus_error_i (bus_error_i),
        .busy_o      (busy_o),
        .error_o     (error_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full-output snapshot: grant, owner, bus_req, busy, error, timeout.
    task automatic chk_all(input string tag, input logic [2:0] g, input logic [2:0] o,
                           input logic br, input logic bz, input logic e, input logic t);
        chk({tag, ".grant"}, 32'(grant_o), 32'(g));
        chk({tag, ".owner"}, 32'(owner_o), 32'(o));
        chk({tag, ".bus_req"}, 32'(bus_req_o), 32'(br));
        chk({tag, ".busy"}, 32'(busy_o), 32'(bz));
        chk({tag, ".error"}, 32'(error_o), 32'(e));
        chk({tag, ".timeout"}, 32'(timeout_o), 32'(t));
    endtask

    initial begin
        logic [2:0] order [4];
        order = '{3'd0, 3'd1, 3'd2, 3'd0};

        reset_n_i   = 1'b0;
        stop_i      = 1'b0;
        req_i       = '0;
        size_i      = '0;
        bus_grant_i = 1'b0;
        bus_beat_i  = 1'b0;
        bus_error_i = 1'b0;
        #12;
        chk_all("reset", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.size", 32'(bus_size_o), 32'd0);
        reset_n_i = 1'b1;
        step();

        // Single read, size 9 -> 4 beats, grant after 2 ask cycles.
        req_i  = 3'b001;
        size_i = {4'd3, 4'd3, 4'd9};
        step();
        chk_all("rd.ask1", 3'b000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rd.size", 32'(bus_size_o), 32'd9);
        step();
        chk_all("rd.ask2", 3'b000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus_grant_i = 1'b1;
        step();
        chk_all("rd.own", 3'b001, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus_grant_i = 1'b0;
        bus_beat_i  = 1'b1;
        for (int b = 1; b <= 3; b++) begin
            step();
            chk("rd.beat.grant", 32'(grant_o), 32'b001);
        end
        step();
        chk_all("rd.release", 3'b000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus_beat_i = 1'b0;
        req_i      = 3'b000;
        step();
        chk_all("rd.idle", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset so that contention starts from pointer 0.
        reset_n_i = 1'b0;
        #2;
        reset_n_i = 1'b1;
        step();

        // Contention: all three request size 3; expect 0,1,2,0.
        req_i  = 3'b111;
        size_i = {4'd3, 4'd3, 4'd3};
        for (int n = 0; n < 4; n++) begin
            step();
            chk("rr.ask.owner", 32'(owner_o), 32'(order[n]));
            chk("rr.ask.bus_req", 32'(bus_req_o), 32'd1);
            bus_grant_i = 1'b1;
            step();
            chk("rr.own.grant", 32'(grant_o), 32'(3'b001 << order[n]));
            bus_grant_i = 1'b0;
            bus_beat_i  = 1'b1;
            step();
            chk("rr.rel.grant", 32'(grant_o), 32'd0);
            chk("rr.rel.busy", 32'(busy_o), 32'd1);
            bus_beat_i = 1'b0;
            step();
            chk("rr.idle.busy", 32'(busy_o), 32'd0);
        end
        req_i = 3'b000;
        step();

        // Illegal size 5 on requester 1 (pointer is 1 here).
        req_i  = 3'b010;
        size_i = {4'd3, 4'd5, 4'd3};
        step();
        chk_all("ill.release", 3'b000, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        req_i = 3'b000;
        step();
        chk_all("ill.idle", 3'b000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Pointer must now be 2: all requesting, 2 wins.
        req_i  = 3'b111;
        size_i = {4'd3, 4'd3, 4'd3};
        step();
        chk_all("ill.ptr", 3'b000, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        // Requester drops while asking: release without error.
        req_i = 3'b000;
        step();
        chk_all("drop.release", 3'b000, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("drop.idle.busy", 32'(busy_o), 32'd0);

        // Timeout: pointer 0, size 8, one beat then silence.
        req_i  = 3'b001;
        size_i = {4'd3, 4'd3, 4'd8};
        step();
        chk("to.ask.size", 32'(bus_size_o), 32'd8);
        bus_grant_i = 1'b1;
        step();
        bus_grant_i = 1'b0;
        bus_beat_i  = 1'b1;
        step();
        chk("to.beat.grant", 32'(grant_o), 32'b001);
        bus_beat_i = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk("to.wait.grant", 32'(grant_o), 32'b001);
            chk("to.wait.error", 32'(error_o), 32'd0);
        end
        step();
        chk_all("to.fire", 3'b000, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        req_i = 3'b000;
        step();
        chk_all("to.idle", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bus error on the same edge as the last beat (pointer 1).
        req_i  = 3'b010;
        size_i = {4'd3, 4'd3, 4'd3};
        step();
        chk("be.ask.owner", 32'(owner_o), 32'd1);
        bus_grant_i = 1'b1;
        step();
        bus_grant_i = 1'b0;
        bus_beat_i  = 1'b1;
        bus_error_i = 1'b1;
        step();
        chk_all("be.release", 3'b000, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        bus_beat_i  = 1'b0;
        bus_error_i = 1'b0;
        req_i       = 3'b000;
        step();
        chk_all("be.idle", 3'b000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Bus error while idle is ignored.
        bus_error_i = 1'b1;
        step();
        chk("be.idle.ignored", 32'(error_o), 32'd0);
        bus_error_i = 1'b0;

        // Stop while owned (pointer 2): everything zero next edge.
        req_i  = 3'b100;
        size_i = {4'd9, 4'd3, 4'd3};
        step();
        bus_grant_i = 1'b1;
        step();
        chk("stop.own.grant", 32'(grant_o), 32'b100);
        bus_grant_i = 1'b0;
        bus_beat_i  = 1'b1;
        step();
        bus_beat_i = 1'b0;
        stop_i     = 1'b1;
        step();
        chk_all("stop.idle", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stop.size", 32'(bus_size_o), 32'd0);
        stop_i = 1'b0;
        req_i  = 3'b111;
        step();
        chk("stop.ptr.kept", 32'(owner_o), 32'd2);

        // Reset in the middle of an ownership: outputs clear immediately.
        bus_grant_i = 1'b1;
        step();
        chk("rst.own.grant", 32'(grant_o), 32'b100);
        bus_grant_i = 1'b0;
        req_i       = 3'b000;
        reset_n_i   = 1'b0;
        #1;
        chk_all("rst.async", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.async.size", 32'(bus_size_o), 32'd0);
        #2;
        reset_n_i = 1'b1;
        step();
        chk("rst.after.busy", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
